// File: rtl/pio_edge_irq.sv
// Avalon-MM parallel I/O port with per-bit direction, 2-flop input sync, edge capture and masked irq.
// Optional atomic out-set/out-clear registers at addresses 4/5 when PIO_EDGE_IRQ_BITSETCLR_EN is defined.
module pio_edge_irq #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET  = '0,
  parameter int                    EDGE_TYPE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe_port,
  output logic                  irq
);

  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_DIR     = 3'd1,
    ADDR_MASK    = 3'd2,
    ADDR_CAPTURE = 3'd3,
    ADDR_OUT_SET = 3'd4,
    ADDR_OUT_CLR = 3'd5
  } reg_addr_e;

  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [DATA_WIDTH-1:0] sync1_q, sync1_d;
  logic [DATA_WIDTH-1:0] sync2_q, sync2_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = sync2_q & ~prev_q;
      1:       edge_det = ~sync2_q & prev_q;
      default: edge_det = sync2_q ^ prev_q;
    endcase
  end

  // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    mask_d  = mask_q;
    cap_d   = cap_q;
    sync1_d = in_port;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    out_d  = wd;
        ADDR_DIR:     dir_d  = wd;
        ADDR_MASK:    mask_d = wd;
        ADDR_CAPTURE: cap_d  = cap_q & ~wd;
`ifdef PIO_EDGE_IRQ_BITSETCLR_EN
        ADDR_OUT_SET: out_d  = out_q | wd;
        ADDR_OUT_CLR: out_d  = out_q & ~wd;
`endif
        default: ;
      endcase
    end
    // A new edge is ORed in after the W1C so a simultaneous set wins.
    cap_d = cap_d | (edge_det & ~dir_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= OUT_RESET;
      dir_q   <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Zero-latency read path; output bits read back the register, input bits the synchronised pin.
  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_DATA:    rd_data = (out_q & dir_q) | (sync2_q & ~dir_q);
      ADDR_DIR:     rd_data = dir_q;
      ADDR_MASK:    rd_data = mask_q;
      ADDR_CAPTURE: rd_data = cap_q;
      default:      rd_data = '0;
    endcase
    readdata                 = '0;
    readdata[DATA_WIDTH-1:0] = rd_data;
  end

  assign out_port = out_q;
  assign oe_port  = dir_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_edge_irq.sv
// Self-checking bench for pio_edge_irq: directed vector table, hand sequences, and randomized
// traffic against a delay-line reference model. Two DUTs (rising, any-edge) share one bus.
module tb_pio_edge_irq;

`ifdef PIO_EDGE_IRQ_BITSETCLR_EN
  localparam bit SETCLR = 1'b1;
`else
  localparam bit SETCLR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd_r, rd_a;
  logic [7:0]  out_r, out_a, oe_r, oe_a;
  logic        irq_r, irq_a;

  int tests = 0;
  int fails = 0;

  pio_edge_irq #(.DATA_WIDTH(8), .OUT_RESET(8'hA5), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_r), .in_port(in_port),
    .out_port(out_r), .oe_port(oe_r), .irq(irq_r));

  pio_edge_irq #(.DATA_WIDTH(8), .OUT_RESET(8'hA5), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_port),
    .out_port(out_a), .oe_port(oe_a), .irq(irq_a));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       cs;
    logic       wn;
    logic [2:0] addr;
    logic [7:0] wd;
    logic [7:0] pin;
    logic [7:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vec [NVEC];

  // Reference model: registers as plain values, the pin path as a history of sampled pins.
  // hist[k] holds the pin value sampled k+1 edges ago; the capture logic sees hist[1] vs hist[2].
  logic [7:0] m_out, m_dir, m_mask, m_cap_r, m_cap_a;
  logic [7:0] hist [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cs, input logic wn, input logic [2:0] a,
                       input logic [7:0] d, input logic [7:0] pin);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = {24'h0, d};
    in_port    = pin;
  endtask

  task automatic model_reset();
    m_out = 8'hA5; m_dir = 8'h00; m_mask = 8'h00; m_cap_r = 8'h00; m_cap_a = 8'h00;
    for (int k = 0; k < 3; k++) hist[k] = 8'h00;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a, input logic [7:0] cap);
    case (a)
      3'd0:    return {24'h0, (m_out & m_dir) | (hist[1] & ~m_dir)};
      3'd1:    return {24'h0, m_dir};
      3'd2:    return {24'h0, m_mask};
      3'd3:    return {24'h0, cap};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic cs, input logic wn, input logic [2:0] a,
                            input logic [7:0] d, input logic [7:0] pin);
    logic       w;
    logic [7:0] now_v, old_v;
    w     = cs && !wn;
    now_v = hist[1];
    old_v = hist[2];
    if (w && a == 3'd3) begin
      m_cap_r = m_cap_r & ~d;
      m_cap_a = m_cap_a & ~d;
    end
    m_cap_r = m_cap_r | ((now_v & ~old_v) & ~m_dir);
    m_cap_a = m_cap_a | ((now_v ^ old_v) & ~m_dir);
    if (w) begin
      if (a == 3'd0) m_out = d;
      if (a == 3'd1) m_dir = d;
      if (a == 3'd2) m_mask = d;
      if (SETCLR && a == 3'd4) m_out = m_out | d;
      if (SETCLR && a == 3'd5) m_out = m_out & ~d;
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = pin;
  endtask

  task automatic do_reset(input logic [7:0] pin);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b1, 3'd0, 8'h00, pin);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [7:0] pin);
    drive(1'b1, 1'b0, a, d, pin);
    @(negedge clk);
    drive(1'b0, 1'b1, a, 8'h00, pin);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b1, 3'd0, 8'h00, 8'hFF);

    //            cs    wn    addr  wd     pin    exp_rd exp_irq
    vec[0]  = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hFF, 8'h00, 1'b0};
    vec[1]  = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hFF, 8'h00, 1'b0};
    vec[2]  = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hFF, 8'h00, 1'b0};
    vec[3]  = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hFF, 8'hFF, 1'b0};
    vec[4]  = '{1'b1, 1'b0, 3'd3, 8'hFF, 8'hFF, 8'hFF, 1'b0};
    vec[5]  = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hFF, 8'h00, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 3'd1, 8'h0F, 8'hFF, 8'h00, 1'b0};
    vec[7]  = '{1'b1, 1'b0, 3'd0, 8'h3C, 8'hA0, 8'hF5, 1'b0};
    vec[8]  = '{1'b1, 1'b1, 3'd0, 8'h00, 8'hA0, 8'hFC, 1'b0};
    vec[9]  = '{1'b1, 1'b1, 3'd0, 8'h00, 8'hA0, 8'hAC, 1'b0};
    vec[10] = '{1'b1, 1'b1, 3'd1, 8'h00, 8'hA0, 8'h0F, 1'b0};
    vec[11] = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hA0, 8'h00, 1'b0};
    vec[12] = '{1'b1, 1'b0, 3'd1, 8'h00, 8'hA0, 8'h0F, 1'b0};
    vec[13] = '{1'b1, 1'b0, 3'd2, 8'h01, 8'hA1, 8'h00, 1'b0};
    vec[14] = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hA1, 8'h00, 1'b0};
    vec[15] = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hA1, 8'h00, 1'b0};
    vec[16] = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hA0, 8'h01, 1'b1};
    vec[17] = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hA0, 8'h01, 1'b1};
    vec[18] = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hA0, 8'h01, 1'b1};
    vec[19] = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hA1, 8'h01, 1'b1};
    vec[20] = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hA1, 8'h01, 1'b1};
    vec[21] = '{1'b1, 1'b0, 3'd3, 8'h01, 8'hA1, 8'h01, 1'b1};
    vec[22] = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hA1, 8'h01, 1'b1};
    vec[23] = '{1'b1, 1'b0, 3'd3, 8'h01, 8'hA1, 8'h01, 1'b1};
    vec[24] = '{1'b1, 1'b1, 3'd3, 8'h00, 8'hA1, 8'h00, 1'b0};
    vec[25] = '{1'b1, 1'b0, 3'd6, 8'hFF, 8'hA1, 8'h00, 1'b0};
    vec[26] = '{1'b1, 1'b1, 3'd2, 8'h00, 8'hA1, 8'h01, 1'b0};
    vec[27] = '{1'b1, 1'b1, 3'd7, 8'h00, 8'hA1, 8'h00, 1'b0};
    vec[28] = '{1'b0, 1'b0, 3'd2, 8'h00, 8'hA1, 8'h01, 1'b0};
    vec[29] = '{1'b1, 1'b1, 3'd2, 8'h00, 8'hA1, 8'h01, 1'b0};
    vec[30] = '{1'b1, 1'b1, 3'd0, 8'h00, 8'hA1, 8'hA1, 1'b0};

    // Reset with pins held high, then the directed table.
    do_reset(8'hFF);
    #1;
    check("rst_out_port", {24'h0, out_r}, 32'h0000_00A5);
    check("rst_oe_port", {24'h0, oe_r}, 32'h0);
    check("rst_irq", {31'h0, irq_r}, 32'h0);
    for (int i = 0; i < NVEC; i++) begin
      drive(vec[i].cs, vec[i].wn, vec[i].addr, vec[i].wd, vec[i].pin);
      #1;
      check($sformatf("vec%0d_rd", i), rd_r, {24'h0, vec[i].exp_rd});
      check($sformatf("vec%0d_irq", i), {31'h0, irq_r}, {31'h0, vec[i].exp_irq});
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 3'd0, 8'h00, 8'hA1);
    #1;
    check("dir_out_port", {24'h0, out_r}, 32'h0000_003C);
    check("dir_oe_port", {24'h0, oe_r}, 32'h0);

    // Atomic set/clear registers.
    @(negedge clk);
    wr(3'd0, 8'h00, 8'hA1);
    wr(3'd4, 8'h81, 8'hA1);
    #1;
    check("set_out_port", {24'h0, out_r}, {24'h0, SETCLR ? 8'h81 : 8'h00});
    @(negedge clk);
    wr(3'd5, 8'h01, 8'hA1);
    #1;
    check("clr_out_port", {24'h0, out_r}, {24'h0, SETCLR ? 8'h80 : 8'h00});
    address = 3'd4;
    #1;
    check("rd_addr4", rd_r, 32'h0);
    address = 3'd5;
    #1;
    check("rd_addr5", rd_r, 32'h0);

    // Mask in an already-set bit: irq rises the cycle after the mask write.
    @(negedge clk);
    wr(3'd2, 8'h00, 8'hA1);
    repeat (3) begin drive(1'b0, 1'b1, 3'd3, 8'h00, 8'hA3); @(negedge clk); end
    #1;
    check("premask_cap", rd_r, 32'h0000_0002);
    check("premask_irq", {31'h0, irq_r}, 32'h0);
    @(negedge clk);
    wr(3'd2, 8'h02, 8'hA3);
    #1;
    check("postmask_irq", {31'h0, irq_r}, 32'h1);

    // Asynchronous reset with everything captured and unmasked.
    @(negedge clk);
    wr(3'd2, 8'hFF, 8'hA3);
    repeat (4) begin drive(1'b0, 1'b1, 3'd3, 8'h00, 8'h00); @(negedge clk); end
    repeat (4) begin drive(1'b0, 1'b1, 3'd3, 8'h00, 8'hFF); @(negedge clk); end
    #1;
    check("pre_arst_cap", rd_r, 32'h0000_00FF);
    check("pre_arst_irq", {31'h0, irq_r}, 32'h1);
    check("pre_arst_irq_any", {31'h0, irq_a}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("arst_irq", {31'h0, irq_r}, 32'h0);
    check("arst_irq_any", {31'h0, irq_a}, 32'h0);
    check("arst_cap", rd_r, 32'h0);
    check("arst_out_port", {24'h0, out_r}, 32'h0000_00A5);
    check("arst_oe_port", {24'h0, oe_r}, 32'h0);
    address = 3'd2;
    #1;
    check("arst_mask", rd_r, 32'h0);

    // Randomized traffic against the reference model, both edge modes.
    do_reset(8'h00);
    for (int n = 0; n < 1500; n++) begin
      logic       r_cs, r_wn;
      logic [2:0] r_a;
      logic [7:0] r_d, r_pin;
      r_cs  = ($urandom_range(0, 3) != 0);
      r_wn  = $urandom_range(0, 1) == 1;
      r_a   = 3'($urandom_range(0, 7));
      r_d   = 8'($urandom);
      r_pin = ($urandom_range(0, 2) == 0) ? 8'($urandom) : in_port;
      drive(r_cs, r_wn, r_a, r_d, r_pin);
      #1;
      check($sformatf("rnd%0d_rd_rise", n), rd_r, m_read(r_a, m_cap_r));
      check($sformatf("rnd%0d_rd_any", n), rd_a, m_read(r_a, m_cap_a));
      check($sformatf("rnd%0d_irq_rise", n), {31'h0, irq_r}, {31'h0, |(m_cap_r & m_mask)});
      check($sformatf("rnd%0d_irq_any", n), {31'h0, irq_a}, {31'h0, |(m_cap_a & m_mask)});
      check($sformatf("rnd%0d_out", n), {24'h0, out_r}, {24'h0, m_out});
      check($sformatf("rnd%0d_oe", n), {24'h0, oe_a}, {24'h0, m_dir});
      @(posedge clk);
      model_step(r_cs, r_wn, r_a, r_d, r_pin);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
